// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : EX-stage branch resolution with a direct-mapped BTB (2-bit
//            counters) for same-cycle IF prediction, plus mispredict stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_branch,
    input  logic              ex_jalr,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [31:0]       pc_imm,
    output logic [31:0]       pc_four,
    output logic [31:0]       br_pc,
    output logic              pc_sel,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [PC_W-1:0]   r_target [ENTRIES];
    logic [STAT_W-1:0] r_branch_count;
    logic [STAT_W-1:0] r_mispredict_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic              w_pred_taken;
    logic [31:0]       w_if_pc_ext;

    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic [31:0]       w_ex_pc_ext;
    logic              w_res;
    logic              w_act_taken;
    logic [31:0]       w_act_target;
    logic              w_mispredict;

    // ---------------- Fetch-side prediction ----------------
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[PC_W-1:IDX_W+2];
    assign w_if_pc_ext = {{(32-PC_W){1'b0}}, if_pc};
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    // Synchronous reset leaves stale table state during the reset cycle.
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1] && !reset;

    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_taken ? {{(32-PC_W){1'b0}}, r_target[w_if_idx]}
                                      : w_if_pc_ext + 32'd4;

    // ---------------- EX-side resolution ----------------
    assign w_ex_pc_ext = {{(32-PC_W){1'b0}}, ex_pc};
    assign pc_imm      = w_ex_pc_ext + ex_imm;
    assign pc_four     = w_ex_pc_ext + 32'd4;

    assign w_res        = ex_valid && (ex_branch || ex_jalr) && !reset;
    // JALR takes priority when both type flags are (illegally) high.
    assign w_act_taken  = ex_jalr || (ex_branch && ex_alu_result[0]);
    assign w_act_target = ex_jalr ? {ex_alu_result[31:1], 1'b0} : pc_imm;
    assign w_mispredict = w_res && ((w_act_taken != ex_pred_taken) ||
                          (w_act_taken && (ex_pred_target != w_act_target)));

    assign pc_sel = w_mispredict;
    assign br_pc  = !w_mispredict ? 32'd0 : (w_act_taken ? w_act_target : pc_four);

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // ---------------- Table and statistics update ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'd1;
                r_target[i] <= '0;
            end
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_res) begin
                r_branch_count <= r_branch_count + 1'b1;
                if (w_ex_hit) begin
                    if (w_act_taken) begin
                        if (r_ctr[w_ex_idx] != 2'd3) begin
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                        end
                        r_target[w_ex_idx] <= w_act_target[PC_W-1:0];
                    end else if (r_ctr[w_ex_idx] != 2'd0) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else if (w_act_taken) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_ctr[w_ex_idx]    <= 2'd2;
                    r_target[w_ex_idx] <= w_act_target[PC_W-1:0];
                end
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic compared against a table-level reference model.
`default_nettype none

module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_jalr;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc_imm;
    logic [31:0] pc_four;
    logic [31:0] br_pc;
    logic        pc_sel;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .STAT_W(16)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_branch        (ex_branch),
        .ex_jalr          (ex_jalr),
        .ex_alu_result    (ex_alu_result),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .pc_imm           (pc_imm),
        .pc_four          (pc_four),
        .br_pc            (br_pc),
        .pc_sel           (pc_sel),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: one record per BTB slot, in plain integers.
    bit          m_valid [16];
    int          m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic [15:0] m_bc;
    logic [15:0] m_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic bit model_hit(input logic [8:0] pc);
        int idx = (int'(pc) / 4) % 16;
        return m_valid[idx] && (m_tag[idx] == int'(pc) / 64);
    endfunction

    function automatic bit model_ptaken(input logic [8:0] pc);
        return model_hit(pc) && (m_ctr[(int'(pc) / 4) % 16] >= 2);
    endfunction

    function automatic logic [31:0] model_ptarget(input logic [8:0] pc);
        if (model_ptaken(pc)) return m_tgt[(int'(pc) / 4) % 16];
        return {23'd0, pc} + 32'd4;
    endfunction

    // Check one cycle of combinational outputs, clock it, update the model,
    // and check the statistics counters.
    task automatic do_cycle();
        bit          e_pt, res, at, mis;
        logic [31:0] e_ptg, atg, e_bpc;
        int          idx;
        #2;
        e_pt  = reset ? 1'b0 : model_ptaken(if_pc);
        e_ptg = reset ? ({23'd0, if_pc} + 32'd4) : model_ptarget(if_pc);
        res   = ex_valid && (ex_branch || ex_jalr) && !reset;
        at    = ex_jalr || (ex_branch && ex_alu_result[0]);
        atg   = ex_jalr ? (ex_alu_result & 32'hFFFF_FFFE) : ({23'd0, ex_pc} + ex_imm);
        mis   = res && ((at != ex_pred_taken) || (at && ex_pred_target != atg));
        e_bpc = !mis ? 32'd0 : (at ? atg : {23'd0, ex_pc} + 32'd4);
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e_pt});
        chk("pred_target", pred_target, e_ptg);
        chk("pc_imm",      pc_imm, {23'd0, ex_pc} + ex_imm);
        chk("pc_four",     pc_four, {23'd0, ex_pc} + 32'd4);
        chk("pc_sel",      {31'd0, pc_sel}, {31'd0, mis});
        chk("br_pc",       br_pc, e_bpc);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (res) begin
            idx = (int'(ex_pc) / 4) % 16;
            m_bc++;
            if (mis) m_mc++;
            if (model_hit(ex_pc)) begin
                if (at) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = atg & 32'h1FF;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (at) begin
                m_valid[idx] = 1; m_tag[idx] = int'(ex_pc) / 64;
                m_ctr[idx] = 2;   m_tgt[idx] = atg & 32'h1FF;
            end
        end
        #1;
        chk("branch_count",     {16'd0, branch_count},     {16'd0, m_bc});
        chk("mispredict_count", {16'd0, mispredict_count}, {16'd0, m_mc});
    endtask

    task automatic set_ex(input bit v, input bit br, input bit jr, input logic [8:0] pc,
                          input logic [31:0] imm, input logic [31:0] alu,
                          input bit pt, input logic [31:0] ptg);
        ex_valid = v; ex_branch = br; ex_jalr = jr; ex_pc = pc; ex_imm = imm;
        ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    initial begin
        logic [8:0] pool [24];
        int         r;
        model_reset();
        reset = 1'b1;
        if_pc = 9'h000;
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        @(posedge clk); #1;
        do_cycle();
        do_cycle();

        // Reset state
        reset = 1'b0; if_pc = 9'h040;
        #2;
        chk("s1_ptaken", {31'd0, pred_taken}, 32'd0);
        chk("s1_ptgt",   pred_target, 32'h44);
        chk("s1_bcnt",   {16'd0, branch_count}, 32'd0);
        do_cycle();

        // Cold taken branch
        set_ex(1, 1, 0, 9'h040, 32'h20, 32'd1, 0, 32'h44);
        #2;
        chk("s2_pcsel", {31'd0, pc_sel}, 32'd1);
        chk("s2_brpc",  br_pc, 32'h60);
        do_cycle();
        chk("s2_bcnt", {16'd0, branch_count}, 32'd1);
        chk("s2_mcnt", {16'd0, mispredict_count}, 32'd1);
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        #2;
        chk("s2_ptaken", {31'd0, pred_taken}, 32'd1);
        chk("s2_ptgt",   pred_target, 32'h60);
        do_cycle();

        // Hysteresis
        set_ex(1, 1, 0, 9'h040, 32'h20, 32'd1, 1, 32'h60);
        #2; chk("s3_pcsel_ok", {31'd0, pc_sel}, 32'd0);
        do_cycle();
        set_ex(1, 1, 0, 9'h040, 32'h20, 32'd0, 1, 32'h60);
        #2;
        chk("s3_pcsel_nt", {31'd0, pc_sel}, 32'd1);
        chk("s3_brpc_nt",  br_pc, 32'h44);
        do_cycle();
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        #2; chk("s3_still_taken", {31'd0, pred_taken}, 32'd1);
        do_cycle();
        set_ex(1, 1, 0, 9'h040, 32'h20, 32'd0, 1, 32'h60);
        do_cycle();
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        #2; chk("s3_now_nt", {31'd0, pred_taken}, 32'd0);
        do_cycle();

        // Alias replacement
        set_ex(1, 1, 0, 9'h140, 32'h10, 32'd1, 0, 32'h144);
        do_cycle();
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        #2; chk("s4_alias_miss", pred_target, 32'h44);
        do_cycle();
        if_pc = 9'h140;
        #2; chk("s4_new_tgt", pred_target, 32'h150);
        do_cycle();

        // JALR target check
        set_ex(1, 0, 1, 9'h080, 32'd0, 32'h0AB, 1, 32'h0AA);
        #2; chk("s5_jalr_ok", {31'd0, pc_sel}, 32'd0);
        do_cycle();
        set_ex(1, 0, 1, 9'h080, 32'd0, 32'h0AB, 1, 32'h0B0);
        #2;
        chk("s5_jalr_bad", {31'd0, pc_sel}, 32'd1);
        chk("s5_jalr_brpc", br_pc, 32'h0AA);
        do_cycle();

        // Stall and mid-operation reset
        set_ex(0, 1, 0, 9'h040, 32'h20, 32'd1, 0, 32'h44);
        #2; chk("s6_stall_pcsel", {31'd0, pc_sel}, 32'd0);
        do_cycle();
        reset = 1'b1;
        set_ex(1, 1, 0, 9'h040, 32'h20, 32'd1, 0, 32'h44);
        #2;
        chk("s6_rst_pcsel", {31'd0, pc_sel}, 32'd0);
        chk("s6_rst_brpc",  br_pc, 32'd0);
        do_cycle();
        reset = 1'b0; if_pc = 9'h140;
        set_ex(0, 0, 0, 9'h000, 32'd0, 32'd0, 0, 32'd0);
        #2;
        chk("s6_cleared_pred", {31'd0, pred_taken}, 32'd0);
        chk("s6_cleared_bcnt", {16'd0, branch_count}, 32'd0);
        do_cycle();

        // Randomized traffic over a small PC pool so entries hit and alias
        for (int i = 0; i < 24; i++) pool[i] = 9'($urandom_range(0, 126) * 4);
        for (int n = 0; n < 500; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            ex_pc    = pool[$urandom_range(0, 23)];
            if_pc    = ($urandom_range(0, 2) == 0) ? ex_pc : pool[$urandom_range(0, 23)];
            ex_valid = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 7);
            ex_branch = (r <= 3) || (r == 6);
            ex_jalr   = (r == 4) || (r == 5) || (r == 6);
            ex_imm        = 32'($urandom_range(0, 64) * 4) - 32'd128;
            ex_alu_result = ex_jalr ? 32'($urandom_range(0, 511)) : 32'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = model_ptaken(ex_pc);
                ex_pred_target = model_ptarget(ex_pc);
            end else begin
                ex_pred_taken  = 1'($urandom);
                ex_pred_target = ex_jalr ? (ex_alu_result & 32'hFFFF_FFFE)
                                         : ({23'd0, ex_pc} + ex_imm);
                if ($urandom_range(0, 3) == 0) ex_pred_target = ex_pred_target + 32'd4;
            end
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch-resolution and prediction unit for the RISC-V pipeline. It keeps the EX-stage resolution function: PC+Imm, PC+4, a branch/JALR redirect, and a PC select. It adds a direct-mapped branch target buffer with 2-bit saturating counters, giving IF a same-cycle prediction, and it reports mispredictions so the pipeline can flush. Two wrapping statistics counters support performance measurement.

## Interface

Parameters:
- PC_W, 9, width of the program counter; must satisfy PC_W ≥ IDX_W+3.
- ENTRIES, 16, number of BTB entries; power of two. IDX_W = log2(ENTRIES), TAG_W = PC_W−IDX_W−2.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  PC_W  fetch-stage PC.
- pred_taken  out  1  prediction for if_pc: 1 means predicted taken.
- pred_target  out  32  predicted next PC, zero-extended.
- ex_valid  in  1  EX stage holds a valid, non-stalled instruction.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_imm  in  32  immediate of the EX instruction.
- ex_branch  in  1  EX instruction is a conditional branch or JAL.
- ex_jalr  in  1  EX instruction is JALR.
- ex_alu_result  in  32  bit 0 is the branch condition; the full value is the JALR target.
- ex_pred_taken  in  1  pred_taken, piped to EX with the instruction.
- ex_pred_target  in  32  pred_target, piped to EX with the instruction.
- pc_imm  out  32  ex_pc (zero-extended) + ex_imm.
- pc_four  out  32  ex_pc (zero-extended) + 4.
- br_pc  out  32  redirect target; 0 when pc_sel=0.
- pc_sel  out  1  mispredict: redirect fetch to br_pc and flush IF/ID.
- branch_count  out  STAT_W  number of resolved control-flow instructions.
- mispredict_count  out  STAT_W  number of mispredictions.

## Operation

- BTB entry contents: valid, tag[TAG_W], ctr[2], target[PC_W]. Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Prediction (combinational from if_pc and table state):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, zero-extended to 32 bits.
- Resolution applies only when res = ex_valid && (ex_branch || ex_jalr) && !reset.
  - act_taken = ex_jalr || (ex_branch && ex_alu_result[0]).
  - act_target = ex_jalr ? {ex_alu_result[31:1],1'b0} : pc_imm.
  - mispredict = res && (act_taken != ex_pred_taken || (act_taken && ex_pred_target != act_target)).
  - pc_sel = mispredict.
  - br_pc = !pc_sel ? 0 : act_taken ? act_target : pc_four.
- Table update on the clock edge when res, at index(ex_pc):
  - Hit, taken: ctr saturates up toward 3; target ← act_target[PC_W-1:0].
  - Hit, not taken: ctr saturates down toward 0; target unchanged. A hit never clears valid.
  - Miss, taken: allocate the entry with valid=1, the new tag, ctr=2, target=act_target. Any aliasing entry is overwritten.
  - Miss, not taken: no change.
- Statistics, on the edge: branch_count increments when res; mispredict_count increments when mispredict. Both wrap modulo 2^STAT_W.
- Reset: all valid←0, ctr←1, target←0, both counters←0.

## Timing

- Predict and resolve paths are both combinational, with zero latency, matching the existing pipeline timing of PcSel.
- A table write becomes visible to prediction in the cycle after the edge. A same-cycle read of the entry being written returns the old contents; no bypass is provided.
- Simultaneous if_pc and ex_pc on the same index is legal: the read sees the old state and the write takes effect at the edge.
- ex_valid=0 (stall or bubble) means no update, no counting and pc_sel=0, regardless of the other ex_* inputs.
- ex_branch and ex_jalr both high is not legal. The design must nevertheless treat this case as JALR.
- Reset is honoured mid-operation. While reset=1, pc_sel=0, br_pc=0 and no update occurs. In the first cycle after reset, pred_taken=0 and pred_target=if_pc+4.
- Output values under reset:
  - pred_taken=0, pred_target=if_pc+4.
  - pc_sel=0, br_pc=0.
  - Counters read 0 from the cycle after the reset edge.
  - pc_imm and pc_four stay purely combinational.

## Test plan

All scenarios use default parameters: index=pc[5:2], tag=pc[8:6].

1. **Reset state:** assert reset for 2 cycles, then set if_pc=0x040. Required: pred_taken=0, pred_target=0x044, both counters 0.
2. **Cold taken branch:** ex_valid=1, ex_branch=1, ex_pc=0x040, ex_imm=0x20, alu[0]=1, ex_pred_taken=0. Required: pc_sel=1, br_pc=0x060, and both counters at 1 after the edge. The next cycle, if_pc=0x040 gives pred_taken=1, pred_target=0x060.
3. **Hysteresis:** continue from scenario 2.
   - Correct taken resolution: pc_sel=0, ctr 2→3.
   - Then not-taken with ex_pred_taken=1: pc_sel=1, br_pc=0x044, ctr=2, still predicts taken.
   - A second not-taken: ctr=1, and if_pc=0x040 now predicts not-taken.
4. **Alias replacement:** taken branch at ex_pc=0x140 with imm=0x10. Required: if_pc=0x040 now misses (pred_target=0x044), and if_pc=0x140 predicts 0x150.
5. **JALR target check:** ex_jalr=1, alu=0x0AB, ex_pred_taken=1, ex_pred_target=0x0AA gives pc_sel=0. The same inputs with ex_pred_target=0x0B0 give pc_sel=1 and br_pc=0x0AA.
6. **Stall and mid-operation reset:** ex_valid=0 with a taken branch gives no counter change and pc_sel=0. reset=1 together with ex_valid=1 on a mispredict gives pc_sel=0, and the table and counters are cleared the next cycle.
